audio_master_link: RTL

// - Master-mode end of the left-justified serial audio link: generates AUD_BCLK and AUD_LRCK from

---
 rtl/audio_master_link.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/audio_master_link.sv
// Master end of a left-justified serial audio link: divides CLOCK_50 into BCLK/LRCK, shifts frames out and in.
// Latency: a TX frame goes out at the next LRCK rise after it is accepted; rx_valid pulses the cycle after the last right-slot bit is sampled.
// Backpressure: one-frame TX holding buffer with a valid/ready handshake; the RX side has none, so each frame must be taken within one frame period.
module audio_master_link #(
  parameter int DATA_WIDTH = 32,
  parameter int BCLK_HALF  = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_left,
  input  logic [DATA_WIDTH-1:0] tx_right,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_left,
  output logic [DATA_WIDTH-1:0] rx_right,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  input  logic                  clear_flags,
  output logic                  AUD_BCLK,
  output logic                  AUD_LRCK,
  output logic                  AUD_DACDAT,
  input  logic                  AUD_ADCDAT
);

  localparam int DW    = DATA_WIDTH;
  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             div_tc;
  logic             bclk_rise;
  logic             bclk_fall;
  logic             slot_end;
  logic             frame_start;
  logic             accept;
  logic             full;
  logic             full_nxt;
  logic             rx_armed;
  logic [DW-1:0]    hold_left;
  logic [DW-1:0]    hold_right;
  logic [DW-1:0]    shadow;
  logic [DW-1:0]    rx_left_cap;
  logic [DW-1:0]    rx_word;
  // The MSB of each word goes straight to AUD_DACDAT on load, so the shifters only keep the rest.
  logic [DW-2:0]    tx_shift;
  logic [DW-2:0]    rx_shift;

  assign div_tc      = (div_cnt == DIV_W'(BCLK_HALF - 1));
  assign bclk_rise   = div_tc & ~AUD_BCLK;
  assign bclk_fall   = div_tc & AUD_BCLK;
  assign slot_end    = (bit_cnt == BIT_W'(DW - 1));
  assign frame_start = bclk_fall & slot_end & ~AUD_LRCK;
  assign accept      = tx_valid & tx_ready;
  assign rx_word     = {rx_shift, AUD_ADCDAT};

  // Bit clock: toggle every BCLK_HALF cycles of CLOCK_50.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      AUD_BCLK <= 1'b0;
    end else if (div_tc) begin
      div_cnt  <= '0;
      AUD_BCLK <= ~AUD_BCLK;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  // Slot sequencing and serializer; everything changes on BCLK falls, MSB aligned with the LRCK edge.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      bit_cnt    <= BIT_W'(DW - 1);
      AUD_LRCK   <= 1'b0;
      AUD_DACDAT <= 1'b0;
      tx_shift   <= '0;
      shadow     <= '0;
    end else if (bclk_fall) begin
      if (slot_end) begin
        bit_cnt  <= '0;
        AUD_LRCK <= ~AUD_LRCK;
        if (!AUD_LRCK) begin
          // Left slot begins: an empty buffer sends a silent frame.
          tx_shift   <= full ? hold_left[DW-2:0] : '0;
          AUD_DACDAT <= full & hold_left[DW-1];
          shadow     <= full ? hold_right : '0;
        end else begin
          tx_shift   <= shadow[DW-2:0];
          AUD_DACDAT <= shadow[DW-1];
        end
      end else begin
        bit_cnt    <= bit_cnt + 1'b1;
        AUD_DACDAT <= tx_shift[DW-2];
        tx_shift   <= {tx_shift[DW-3:0], 1'b0};
      end
    end
  end

  // Holding buffer occupancy: a frame start drains it, an accept (same cycle allowed) refills it.
  always_comb begin
    full_nxt = full;
    if (frame_start) full_nxt = 1'b0;
    if (accept)      full_nxt = 1'b1;
  end

  // Holding buffer, ready flag and sticky underrun; a set beats a simultaneous clear.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      full        <= 1'b0;
      tx_ready    <= 1'b1;
      hold_left   <= '0;
      hold_right  <= '0;
      tx_underrun <= 1'b0;
    end else begin
      full     <= full_nxt;
      tx_ready <= ~full_nxt;
      if (accept) begin
        hold_left  <= tx_left;
        hold_right <= tx_right;
      end
      if (frame_start && !full) tx_underrun <= 1'b1;
      else if (clear_flags)     tx_underrun <= 1'b0;
    end
  end

  // Deserializer: sample on BCLK rises; publish a frame only after a full left slot has been seen.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      rx_shift    <= '0;
      rx_left_cap <= '0;
      rx_left     <= '0;
      rx_right    <= '0;
      rx_valid    <= 1'b0;
      rx_armed    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (bclk_rise) begin
        rx_shift <= rx_word[DW-2:0];
        if (slot_end) begin
          if (AUD_LRCK) begin
            rx_left_cap <= rx_word;
            rx_armed    <= 1'b1;
          end else if (rx_armed) begin
            rx_left  <= rx_left_cap;
            rx_right <= rx_word;
            rx_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule
